conf_rx_deserializer: RTL and testbench
=======================================

# conf_rx_deserializer

Receive-side counterpart of the configuration register readback path. Accepts a stream of RX_WIDTH-bit chunks from the host interface, assembles each frame into an address plus a DATA_WIDTH-bit word, and issues a single-cycle write strobe to the configuration register bank. Malformed frames are discarded: an out-of-range address raises an error pulse, and a stalled partial frame is dropped by a timeout.

## Interface
- NUM_REGS, 16, number of writable configuration registers
- DATA_WIDTH, 16, register width; must be an integer multiple of RX_WIDTH
- RX_WIDTH, 8, incoming chunk width
- ADDR_WIDTH, 8, address field width; must be ≤ RX_WIDTH
- TIMEOUT_CYCLES, 1024, idle cycles tolerated mid-frame; range 1..65535
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rx_data  in  RX_WIDTH  incoming chunk
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  block can accept a chunk; transfer occurs when rx_valid && rx_ready at a clk edge
- wr_en  out  1  one-cycle write strobe to the register bank
- wr_addr  out  ADDR_WIDTH  register address; valid while wr_en is high, then held
- wr_data  out  DATA_WIDTH  register data; valid while wr_en is high, then held
- addr_err  out  1  one-cycle pulse: frame completed with address ≥ NUM_REGS
- timeout  out  1  one-cycle pulse: partial frame aborted
- busy  out  1  high while a frame is partially received or being written

## Operation
- Frame format: chunk 0 is the address, taken from rx_data[ADDR_WIDTH-1:0]. Upper bits are ignored.
- Address is followed by DATA_CHUNKS = DATA_WIDTH/RX_WIDTH data chunks, least-significant first. Chunk k fills wr_data[(k+1)*RX_WIDTH-1 : k*RX_WIDTH].
- States:
  - ST_IDLE: wait for the address chunk. On a transfer, latch the address, clear the chunk counter, go to ST_DATA.
  - ST_DATA: each transfer fills the next data slice and increments the chunk counter. On transfer number DATA_CHUNKS, go to ST_WRITE.
  - ST_WRITE: lasts one cycle. rx_ready is low.
    - If address < NUM_REGS: wr_en = 1.
    - Otherwise: addr_err = 1 and wr_en stays 0.
    - Return to ST_IDLE.
- rx_ready = (state != ST_WRITE) && !rst.
- busy = (state != ST_IDLE).
- Timeout: in ST_DATA, a 16-bit counter increments on every cycle with no transfer and clears on each transfer.
  - When the counter reaches TIMEOUT_CYCLES, pulse timeout for one cycle, discard the partial data, and return to ST_IDLE.
  - The counter is cleared in ST_IDLE.
- Chunk counter width: $clog2(DATA_CHUNKS+1).
- wr_data is assembled in place. wr_addr and wr_data hold their last values until the next frame overwrites them. Their content is only meaningful during wr_en.

## Timing
- Reset: while rst is high, every output is 0 (rx_ready, wr_en, wr_addr, wr_data, addr_err, timeout, busy). state = ST_IDLE and both counters are cleared.
- rx_ready rises in the first cycle after rst deasserts.
- Reset mid-frame: the partial frame is lost. There is no wr_en and no timeout pulse.
- Latency: wr_en (or addr_err) is high in the cycle immediately after the edge that accepts the last data chunk.
- Throughput: minimum (1 + DATA_CHUNKS + 1) cycles per frame, i.e. 4 cycles at the defaults. rx_ready drops for exactly one cycle per frame.
- rx_valid may deassert between chunks without effect, other than advancing the timeout counter.
- A timeout takes effect on the edge where the counter equals TIMEOUT_CYCLES. If a transfer occurs on that same edge, the transfer wins and the counter clears.
- wr_en, addr_err and timeout are mutually exclusive and never high for two consecutive cycles.

## Structure
- The shared header conf_regs_defines.v holds: __NUM_REGS, __DATA_WIDTH, __RX_WIDTH, __ADDR_WIDTH, __TIMEOUT_CYCLES, and the state encodings ST_IDLE=0, ST_DATA=1, ST_WRITE=2.
- A sub-module conf_rx_timeout (counter with clear, enable and terminal pulse) is natural and reusable. Everything else stays in a single module.
- Estimated size: about 150 lines of RTL.

## Test plan
- Single write: chunks 0x03, 0xEF, 0xBE on consecutive cycles → one wr_en cycle with wr_addr=0x03, wr_data=0xBEEF, on the cycle after 0xBE is accepted; busy high for 3 cycles.
- Back-to-back frames with rx_valid held high (03,EF,BE,05,34,12) → rx_ready low for exactly one cycle after each frame; two writes (3←0xBEEF, 5←0x1234) 4 cycles apart.
- Out-of-range: 0x10, 0xAA, 0x55 with NUM_REGS=16 → no wr_en; addr_err pulses once; rx_ready returns high on the next cycle.
- Timeout: 0x03, 0xEF, then 1024 idle cycles → timeout pulses on the 1024th idle cycle with no wr_en. A following frame 0x05, 0x34, 0x12 → write 5←0x1234.
- Gapped input: 0x07, gap of 3 cycles, 0xCD, gap of 10 cycles, 0xAB → write 7←0xABCD; no timeout.
- Reset mid-frame: 0x02, 0x11, assert rst for 1 cycle, then 0x04, 0x22, 0x33 → all outputs 0 during rst; a single write 4←0x3322; no write to address 2.

Source files
------------

// File: rtl/conf_rx_deserializer_pkg.sv
// Shared constants for the configuration receive path: default geometry,
// timeout counter width and the legacy-compatible state encodings.
package conf_rx_deserializer_pkg;

   localparam int NUM_REGS_DEF       = 16;
   localparam int DATA_WIDTH_DEF     = 16;
   localparam int RX_WIDTH_DEF       = 8;
   localparam int ADDR_WIDTH_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   localparam int TIMEOUT_CNT_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DATA  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/conf_rx_deserializer_timeout.sv
// Idle-cycle counter with clear and enable.
// Pulses expire on the enabled cycle that brings the count to LIMIT.
module conf_rx_deserializer_timeout
   import conf_rx_deserializer_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TIMEOUT_CNT_W-1:0] cnt_q;
   logic [TIMEOUT_CNT_W-1:0] cnt_d;
   logic [TIMEOUT_CNT_W-1:0] cnt_inc;

   // Clear wins over enable, so a transfer on the terminal cycle suppresses the pulse.
   always_comb begin
      cnt_inc = cnt_q + TIMEOUT_CNT_W'(1);
      expire  = enable && !clear && (cnt_inc == TIMEOUT_CNT_W'(LIMIT));
      cnt_d   = cnt_q;
      if (clear || expire) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conf_rx_deserializer.sv
// Assembles address + data frames from RX chunks and issues one-cycle
// register writes; bad addresses and stalled frames are dropped.
module conf_rx_deserializer
   import conf_rx_deserializer_pkg::*;
#(
   parameter int NUM_REGS       = NUM_REGS_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int RX_WIDTH       = RX_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RX_WIDTH-1:0]   rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  addr_err,
   output logic                  timeout,
   output logic                  busy
);

   localparam int DATA_CHUNKS = DATA_WIDTH / RX_WIDTH;
   localparam int CNT_W       = $clog2(DATA_CHUNKS + 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      chunk_q, chunk_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic xfer;
   logic addr_ok;
   logic tmo_clear;
   logic tmo_enable;
   logic tmo_expire;

   assign xfer       = rx_valid && (state_q != ST_WRITE);
   assign addr_ok    = (32'(addr_q) < NUM_REGS);
   assign tmo_enable = (state_q == ST_DATA) && !xfer;
   assign tmo_clear  = (state_q != ST_DATA) || xfer;

   conf_rx_deserializer_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expire (tmo_expire)
   );

   // Data slices are filled in place; stale bits from an aborted frame are harmless
   // because wr_data is only meaningful while wr_en is high.
   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               addr_d  = rx_data[ADDR_WIDTH-1:0];
               chunk_d = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               for (int k = 0; k < DATA_CHUNKS; k++) begin
                  if (chunk_q == CNT_W'(k)) begin
                     data_d[k*RX_WIDTH +: RX_WIDTH] = rx_data;
                  end
               end
               chunk_d = chunk_q + CNT_W'(1);
               if (chunk_q == CNT_W'(DATA_CHUNKS - 1)) begin
                  state_d = ST_WRITE;
               end
            end else if (tmo_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         chunk_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Reset is synchronous, so outputs are gated to read zero for the whole rst cycle.
   assign rx_ready = !rst && (state_q != ST_WRITE);
   assign wr_en    = !rst && (state_q == ST_WRITE) && addr_ok;
   assign addr_err = !rst && (state_q == ST_WRITE) && !addr_ok;
   assign timeout  = !rst && tmo_expire;
   assign busy     = !rst && (state_q != ST_IDLE);
   assign wr_addr  = rst ? '0 : addr_q;
   assign wr_data  = rst ? '0 : data_q;

endmodule

// File: tb/tb_conf_rx_deserializer.sv
// Directed bench for conf_rx_deserializer: writes, back-to-back frames,
// bad address, timeout, gapped input and reset mid-frame.
module tb_conf_rx_deserializer;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        addr_err;
   logic        timeout;
   logic        busy;

   int errors = 0;
   int checks = 0;

   conf_rx_deserializer dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .addr_err (addr_err),
      .timeout  (timeout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Control vector order: {rx_ready, wr_en, addr_err, timeout, busy}
   task automatic check_ctrl(input string tag, input logic [4:0] expected);
      check(tag, {27'd0, rx_ready, wr_en, addr_err, timeout, busy}, {27'd0, expected});
   endtask

   task automatic check_write(input string tag, input logic [7:0] addr, input logic [15:0] data);
      check({tag, "_addr"}, {24'd0, wr_addr}, {24'd0, addr});
      check({tag, "_data"}, {16'd0, wr_data}, {16'd0, data});
   endtask

   // Advance one cycle, drive inputs #1 after the edge, sample #1 later.
   task automatic step(input string tag, input logic v, input logic [7:0] d, input logic [4:0] expected);
      @(posedge clk);
      #1;
      rx_valid = v;
      rx_data  = d;
      #1;
      check_ctrl(tag, expected);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      #1;
      check_ctrl("reset_ctrl", 5'b00000);
      check_write("reset", 8'h00, 16'h0000);
      rst      = 1'b0;
      rx_valid = 1'b0;
      #1;
      check_ctrl("post_reset_ready", 5'b10000);

      // Single write 3 <- 0xBEEF
      step("s1_addr", 1'b1, 8'h03, 5'b10000);
      step("s1_d0",   1'b1, 8'hEF, 5'b10001);
      step("s1_d1",   1'b1, 8'hBE, 5'b10001);
      step("s1_wr",   1'b0, 8'h00, 5'b01001);
      check_write("s1", 8'h03, 16'hBEEF);
      step("s1_idle", 1'b0, 8'h00, 5'b10000);

      // Back-to-back frames with rx_valid held high
      step("b2b_a0",  1'b1, 8'h03, 5'b10000);
      step("b2b_a1",  1'b1, 8'hEF, 5'b10001);
      step("b2b_a2",  1'b1, 8'hBE, 5'b10001);
      step("b2b_awr", 1'b1, 8'h05, 5'b01001);
      check_write("b2b_a", 8'h03, 16'hBEEF);
      step("b2b_b0",  1'b1, 8'h05, 5'b10000);
      step("b2b_b1",  1'b1, 8'h34, 5'b10001);
      step("b2b_b2",  1'b1, 8'h12, 5'b10001);
      step("b2b_bwr", 1'b0, 8'h00, 5'b01001);
      check_write("b2b_b", 8'h05, 16'h1234);
      step("b2b_idle", 1'b0, 8'h00, 5'b10000);

      // Out-of-range address
      step("oor_addr", 1'b1, 8'h10, 5'b10000);
      step("oor_d0",   1'b1, 8'hAA, 5'b10001);
      step("oor_d1",   1'b1, 8'h55, 5'b10001);
      step("oor_err",  1'b0, 8'h00, 5'b00101);
      step("oor_idle", 1'b0, 8'h00, 5'b10000);

      // Timeout after 1024 idle cycles mid-frame
      step("to_addr", 1'b1, 8'h03, 5'b10000);
      step("to_d0",   1'b1, 8'hEF, 5'b10001);
      for (int i = 1; i < 1024; i++) begin
         step("to_wait", 1'b0, 8'h00, 5'b10001);
      end
      step("to_pulse", 1'b0, 8'h00, 5'b10011);
      step("to_n_addr", 1'b1, 8'h05, 5'b10000);
      step("to_n_d0",   1'b1, 8'h34, 5'b10001);
      step("to_n_d1",   1'b1, 8'h12, 5'b10001);
      step("to_n_wr",   1'b0, 8'h00, 5'b01001);
      check_write("to_n", 8'h05, 16'h1234);
      step("to_n_idle", 1'b0, 8'h00, 5'b10000);

      // Gapped input
      step("gap_addr", 1'b1, 8'h07, 5'b10000);
      for (int i = 0; i < 3; i++) begin
         step("gap_w1", 1'b0, 8'h00, 5'b10001);
      end
      step("gap_d0", 1'b1, 8'hCD, 5'b10001);
      for (int i = 0; i < 10; i++) begin
         step("gap_w2", 1'b0, 8'h00, 5'b10001);
      end
      step("gap_d1", 1'b1, 8'hAB, 5'b10001);
      step("gap_wr", 1'b0, 8'h00, 5'b01001);
      check_write("gap", 8'h07, 16'hABCD);
      step("gap_idle", 1'b0, 8'h00, 5'b10000);

      // Reset mid-frame
      step("rm_addr", 1'b1, 8'h02, 5'b10000);
      step("rm_d0",   1'b1, 8'h11, 5'b10001);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      rx_valid = 1'b0;
      #1;
      check_ctrl("rm_rst_ctrl", 5'b00000);
      check_write("rm_rst", 8'h00, 16'h0000);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h04;
      #1;
      check_ctrl("rm_n_addr", 5'b10000);
      step("rm_n_d0",   1'b1, 8'h22, 5'b10001);
      step("rm_n_d1",   1'b1, 8'h33, 5'b10001);
      step("rm_n_wr",   1'b0, 8'h00, 5'b01001);
      check_write("rm_n", 8'h04, 16'h3322);
      step("rm_n_idle", 1'b0, 8'h00, 5'b10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
